// File: rtl/nfive32_rf.sv
// NfiVe32 integer register file: x1..x31 in flops, x0 reads as zero.
// Two combinational read ports, one write port committed on the rising edge of HCLK.
module nfive32_rf (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        WR,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  input  logic [4:0]  RW,
  input  logic [31:0] DW,
  output logic [31:0] DA,
  output logic [31:0] DB
);

  logic [31:0] regs [1:31];

  // Writes to x0 never match any storage slot, so they fall away naturally.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
    end else if (WR) begin
      for (int i = 1; i < 32; i++) begin
        if (RW == 5'(i)) regs[i] <= DW;
      end
    end
  end

  always_comb begin
    DA = 32'h0;
    DB = 32'h0;
    for (int i = 1; i < 32; i++) begin
      if (RA == 5'(i)) DA = regs[i];
      if (RB == 5'(i)) DB = regs[i];
    end
  end

endmodule

// File: tb/tb_nfive32_rf.sv
// Self-checking bench for nfive32_rf: directed steps followed by random traffic
// compared against an array-based reference register file.
module tb_nfive32_rf;

  logic        HCLK;
  logic        HRESETn;
  logic        WR;
  logic [4:0]  RA, RB, RW;
  logic [31:0] DW;
  logic [31:0] DA, DB;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [32];

  nfive32_rf dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .WR(WR),
    .RA(RA), .RB(RB), .RW(RW), .DW(DW),
    .DA(DA), .DB(DB)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : mdl[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_da"}, DA, mread(RA));
    check({tag, "_db"}, DB, mread(RB));
  endtask

  // Reference commit happens with the inputs as they stand at the edge.
  task automatic tick();
    if (HRESETn && WR && RW != 5'd0) mdl[RW] = DW;
    @(posedge HCLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] old7;
    HRESETn = 1'b0;
    WR = 1'b0; RA = '0; RB = '0; RW = '0; DW = '0;
    model_clear();
    #12;

    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #1;
      check("rst_sweep_da", DA, 32'h0);
      check("rst_sweep_db", DB, 32'h0);
    end

    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;

    WR = 1'b0; RW = 5'd0; DW = 32'h0; RA = 5'd5; RB = 5'd10;
    tick();
    check("nowrite_da", DA, 32'h0);
    check("nowrite_db", DB, 32'h0);

    WR = 1'b1; RW = 5'd5; DW = 32'd100;
    #1;
    check("prewrite_da", DA, 32'h0);
    tick();
    check("w5_da", DA, 32'd100);
    RW = 5'd10; DW = 32'd200;
    tick();
    check("w10_db", DB, 32'd200);
    check("w10_da", DA, 32'd100);
    RW = 5'd20; DW = 32'd999;
    tick();
    check("w20_da", DA, 32'd100);
    check("w20_db", DB, 32'd200);

    WR = 1'b0; RA = 5'd20; RB = 5'd10; RW = 5'd30; DW = 32'd899;
    tick();
    check("wrdis_da", DA, 32'd999);
    check("wrdis_db", DB, 32'd200);
    RA = 5'd30;
    #1;
    check("wrdis_x30", DA, 32'h0);

    WR = 1'b1; RW = 5'd0; DW = 32'hFFFF_FFFF; RA = 5'd0;
    tick();
    check("x0_da", DA, 32'h0);
    RW = 5'd7; DW = 32'h0000_0042;
    tick();
    old7 = 32'h0000_0042;
    RB = 5'd7; RW = 5'd7; DW = 32'h0000_1234;
    #1;
    check("x7_before_edge", DB, old7);
    tick();
    check("x7_after_edge", DB, 32'h0000_1234);

    RW = 5'd9; DW = 32'hAAAA_0001;
    tick();
    DW = 32'hAAAA_0002;
    tick();
    RA = 5'd9;
    #1;
    check("same_idx_last_wins", DA, 32'hAAAA_0002);

    WR = 1'b1; RW = 5'd5; DW = 32'd100; RA = 5'd5;
    tick();
    check("prerst_x5", DA, 32'd100);
    #2;
    HRESETn = 1'b0;
    model_clear();
    #1;
    check("async_rst_da", DA, 32'h0);
    RW = 5'd5; DW = 32'hDEAD_BEEF;
    tick();
    check("rst_blocks_write", DA, 32'h0);
    #2;
    HRESETn = 1'b1;
    DW = 32'd77;
    tick();
    check("post_rst_write", DA, 32'd77);

    for (int n = 0; n < 400; n++) begin
      WR = 1'($urandom_range(0, 1));
      RW = 5'($urandom_range(0, 31));
      DW = $urandom;
      RA = (n % 5 == 0) ? RW : 5'($urandom_range(0, 31));
      RB = 5'($urandom_range(0, 31));
      #1;
      check_ports("rnd_pre");
      tick();
      check_ports("rnd_post");
    end

    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #1;
      check_ports("final_sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

endmodule
